tour_cmd: RTL and testbench
===========================

TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, meaning the number of knight moves in a full 5x5 tour.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_tour  input  1  one-cycle pulse from TourLogic: solution ready, begin replay.
REQ-005 SHALL have port move  input  8  one-hot move for the current mv_indx, supplied by TourLogic.
REQ-006 SHALL have port mv_indx  output  5  index of the move being replayed.
REQ-007 SHALL have port cmd_UART  input  16  command assembled by UART_wrapper.
REQ-008 SHALL have port cmd_rdy_UART  input  1  cmd_UART valid.
REQ-009 SHALL have port clr_cmd_rdy  input  1  pulse from cmd_proc: current cmd consumed.
REQ-010 SHALL have port send_resp  input  1  pulse from cmd_proc: current move complete.
REQ-011 SHALL have port cmd  output  16  muxed command to cmd_proc.
REQ-012 SHALL have port cmd_rdy  output  1  cmd valid.
REQ-013 SHALL have port resp  output  8  response byte to UART_wrapper.

Function
REQ-014 Command format SHALL be opcode[15:12], heading[11:4], squares[3:0]; opcodes 4'h4 = move, 4'h5 = move with fanfare.
REQ-015 Headings SHALL be N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
REQ-016 Move bits as (dx,dy) SHALL be: 0 (+1,+2), 1 (-1,+2), 2 (-2,+1), 3 (-2,-1), 4 (-1,-2), 5 (+1,-2), 6 (+2,-1), 7 (+2,+1).
REQ-017 Each move SHALL be issued as two commands.
REQ-018 The first command SHALL be the Y leg: opcode 4, heading N if dy>0 else S, squares |dy|.
REQ-019 The second command SHALL be the X leg: opcode 5, heading E if dx>0 else W, squares |dx|.
REQ-020 If move is not one-hot, the lowest set bit SHALL be used.
REQ-021 If move is all zero on entry to VERT, the block SHALL return to IDLE, issue no command, and leave resp at 8'hA5.
REQ-022 The FSM SHALL have exactly the states IDLE, VERT, HOLDV, HORZ and HOLDH.
REQ-023 In IDLE, start_tour SHALL clear mv_indx and go to VERT; otherwise the FSM SHALL stay in IDLE.
REQ-024 In VERT, the FSM SHALL present the Y-leg command with cmd_rdy=1 and go to HOLDV on clr_cmd_rdy.
REQ-025 In HOLDV, cmd_rdy SHALL be 0 and the FSM SHALL go to HORZ on send_resp.
REQ-026 In HORZ, the FSM SHALL present the X-leg command with cmd_rdy=1 and go to HOLDH on clr_cmd_rdy.
REQ-027 In HOLDH, cmd_rdy SHALL be 0; on send_resp, if mv_indx==NUM_MOVES-1 the FSM SHALL go to IDLE, else it SHALL increment mv_indx and go to VERT.
REQ-028 In IDLE, the block SHALL pass cmd_UART and cmd_rdy_UART through combinationally to cmd and cmd_rdy.
REQ-029 In all other states, cmd and cmd_rdy SHALL be decoded only from the registered state, registered mv_indx and move, with no combinational path from cmd_UART or cmd_rdy_UART.
REQ-030 resp SHALL be 8'hA5 in IDLE and whenever the HOLDH-to-IDLE transition occurs (final move).
REQ-031 resp SHALL be 8'h5A in every other non-IDLE state.
REQ-032 start_tour SHALL be ignored outside IDLE; cmd_rdy_UART SHALL be ignored outside IDLE.
REQ-033 If clr_cmd_rdy and send_resp are asserted in the same cycle, only the one relevant to the current state SHALL act.
REQ-034 mv_indx SHALL never exceed NUM_MOVES-1; no wrap SHALL occur.
REQ-035 Latency SHALL be one clk from start_tour to cmd_rdy=1, and one clk from send_resp in HOLDV to the X-leg cmd_rdy=1.

Reset
REQ-036 On rst_n low, the block SHALL asynchronously force state=IDLE and mv_indx=0; outputs then follow IDLE, with cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and resp=8'hA5.
REQ-037 Reset asserted mid-tour SHALL abandon the tour; no resume SHALL occur after release.

Structure
REQ-038 Opcodes, heading constants, response codes and the state enum SHALL live in shared package knights_pkg.
REQ-039 The one-hot-to-(Y cmd, X cmd) decode SHALL be combinational sub-module tour_move_decode.

Verification
REQ-040 Pulse start_tour with move=8'h20 (bit 5), ack each command -> cmd=16'h47F2 then 16'h5BF1, with resp=8'h5A between.
REQ-041 move=8'h01 -> 16'h4002 then 16'h5BF1; move=8'h08 -> 16'h47F1 then 16'h53F2; move=8'h40 -> 16'h47F1 then 16'h5BF2.
REQ-042 Run a full 24-move tour -> mv_indx steps 0..23, resp=8'hA5 on the final send_resp, FSM returns to IDLE, and cmd then equals cmd_UART.
REQ-043 In IDLE with cmd_UART=16'h4BF1 and cmd_rdy_UART=1 -> cmd=16'h4BF1 and cmd_rdy=1; the same stimulus in HOLDV -> cmd_rdy=0.
REQ-044 Assert rst_n low in HORZ at mv_indx=7 -> state=IDLE, mv_indx=0, and a second start_tour restarts the tour at index 0.
REQ-045 Assert clr_cmd_rdy and send_resp together in VERT -> the FSM goes to HOLDV only; move=8'h00 -> the FSM returns to IDLE with no cmd_rdy.

Source files
------------

// File: rtl/knights_pkg.sv
// Shared constants for the knight's-tour command path: opcodes, headings,
// response codes and the replay FSM state encoding.
package knights_pkg;
   localparam logic [3:0] OP_MOVE    = 4'h4;
   localparam logic [3:0] OP_FANFARE = 4'h5;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_BUSY = 8'h5A;

   typedef enum logic [2:0] {IDLE, VERT, HOLDV, HORZ, HOLDH} tour_state_t;
endpackage

// File: rtl/tour_move_decode.sv
// Turns a one-hot knight move into its Y-leg and X-leg commands.
// The lowest set bit wins when more than one bit is set.
module tour_move_decode
   import knights_pkg::*;
(
   input  logic [7:0]  move,
   output logic [15:0] y_cmd,
   output logic [15:0] x_cmd,
   output logic        valid
);

   assign valid = |move;

   always_comb begin
      y_cmd = 16'h0000;
      x_cmd = 16'h0000;
      casez (move)
         8'b???????1: begin y_cmd = {OP_MOVE, HDG_N, 4'd2}; x_cmd = {OP_FANFARE, HDG_E, 4'd1}; end
         8'b??????10: begin y_cmd = {OP_MOVE, HDG_N, 4'd2}; x_cmd = {OP_FANFARE, HDG_W, 4'd1}; end
         8'b?????100: begin y_cmd = {OP_MOVE, HDG_N, 4'd1}; x_cmd = {OP_FANFARE, HDG_W, 4'd2}; end
         8'b????1000: begin y_cmd = {OP_MOVE, HDG_S, 4'd1}; x_cmd = {OP_FANFARE, HDG_W, 4'd2}; end
         8'b???10000: begin y_cmd = {OP_MOVE, HDG_S, 4'd2}; x_cmd = {OP_FANFARE, HDG_W, 4'd1}; end
         8'b??100000: begin y_cmd = {OP_MOVE, HDG_S, 4'd2}; x_cmd = {OP_FANFARE, HDG_E, 4'd1}; end
         8'b?1000000: begin y_cmd = {OP_MOVE, HDG_S, 4'd1}; x_cmd = {OP_FANFARE, HDG_E, 4'd2}; end
         8'b10000000: begin y_cmd = {OP_MOVE, HDG_N, 4'd1}; x_cmd = {OP_FANFARE, HDG_E, 4'd2}; end
         default:     begin y_cmd = 16'h0000;              x_cmd = 16'h0000;                 end
      endcase
   end

endmodule

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as Y/X command pairs to cmd_proc, and
// passes UART commands straight through while no tour is running.
module tour_cmd
   import knights_pkg::*;
#(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic [7:0]  resp
);

   tour_state_t state, nxt_state;
   logic [15:0] y_cmd, x_cmd;
   logic        mv_ok;
   logic        last;

   tour_move_decode u_dec (
      .move  (move),
      .y_cmd (y_cmd),
      .x_cmd (x_cmd),
      .valid (mv_ok)
   );

   assign last = (mv_indx == 5'(NUM_MOVES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   mv_indx <= 5'd0;
      else if (state == IDLE && start_tour)         mv_indx <= 5'd0;
      else if (state == HOLDH && send_resp && !last) mv_indx <= mv_indx + 5'd1;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (start_tour) nxt_state = VERT;
         // an empty move means there is nothing to replay
         VERT:    if (!mv_ok) nxt_state = IDLE;
                  else if (clr_cmd_rdy) nxt_state = HOLDV;
         HOLDV:   if (send_resp) nxt_state = HORZ;
         HORZ:    if (clr_cmd_rdy) nxt_state = HOLDH;
         HOLDH:   if (send_resp) nxt_state = last ? IDLE : VERT;
         default: nxt_state = IDLE;
      endcase
   end

   // Outside IDLE the UART inputs are not selected, so cmd/cmd_rdy depend
   // only on registered state, mv_indx and move.
   always_comb begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
      resp    = RESP_BUSY;
      case (state)
         IDLE:  resp = RESP_DONE;
         VERT:  begin
            cmd     = y_cmd;
            cmd_rdy = mv_ok;
            resp    = mv_ok ? RESP_BUSY : RESP_DONE;
         end
         HOLDV: begin cmd = y_cmd; cmd_rdy = 1'b0; end
         HORZ:  begin cmd = x_cmd; cmd_rdy = 1'b1; end
         HOLDH: begin
            cmd     = x_cmd;
            cmd_rdy = 1'b0;
            resp    = (send_resp && last) ? RESP_DONE : RESP_BUSY;
         end
         default: resp = RESP_DONE;
      endcase
   end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: expected command pairs are queued as each
// move is presented and popped as the DUT raises cmd_rdy.
module tb_tour_cmd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_tour = 1'b0;
   logic [7:0]  move = 8'h00;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART = 16'h0000;
   logic        cmd_rdy_UART = 1'b0;
   logic        clr_cmd_rdy = 1'b0;
   logic        send_resp = 1'b0;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;

   int total = 0;
   int bad = 0;
   logic [15:0] sb[$];
   logic [7:0]  tour[24];

   tour_cmd #(.NUM_MOVES(24)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_tour   (start_tour),
      .move         (move),
      .mv_indx      (mv_indx),
      .cmd_UART     (cmd_UART),
      .cmd_rdy_UART (cmd_rdy_UART),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .send_resp    (send_resp),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .resp         (resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference: knight displacement table, Y leg first then X leg.
   function automatic void model(input logic [7:0] m, output logic [15:0] y, output logic [15:0] x);
      int dxt[8];
      int dyt[8];
      int k;
      int dx, dy;
      dxt = '{1, -1, -2, -2, -1, 1, 2, 2};
      dyt = '{2, 2, 1, -1, -2, -2, -1, 1};
      k = -1;
      for (int i = 7; i >= 0; i--) if (m[i]) k = i;
      y = 16'h0000;
      x = 16'h0000;
      if (k < 0) return;
      dx = dxt[k];
      dy = dyt[k];
      y = {4'h4, (dy > 0) ? 8'h00 : 8'h7F, 4'(dy < 0 ? -dy : dy)};
      x = {4'h5, (dx > 0) ? 8'hBF : 8'h3F, 4'(dx < 0 ? -dx : dx)};
   endfunction

   task automatic push_move(input logic [7:0] m);
      logic [15:0] y, x;
      model(m, y, x);
      sb.push_back(y);
      sb.push_back(x);
      move = m;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start_tour = 1'b1;
      @(posedge clk); #1 start_tour = 1'b0;
   endtask

   // One command leg: expect cmd_rdy one cycle after entry, ack, then finish.
   task automatic leg(input string tag, input int idx, input bit final_ack, input bit both,
                      input bit uart_poke, input bit load, input logic [7:0] nxt);
      logic [15:0] e;
      @(negedge clk);
      chk({tag, "_rdy"}, cmd_rdy, 1);
      chk({tag, "_idx"}, mv_indx, idx);
      e = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
      chk({tag, "_cmd"}, cmd, e);
      chk({tag, "_resp"}, resp, 8'h5A);
      clr_cmd_rdy = 1'b1;
      if (both) send_resp = 1'b1;
      @(posedge clk); #1 clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      if (uart_poke) begin cmd_UART = 16'h4BF1; cmd_rdy_UART = 1'b1; end
      @(negedge clk);
      chk({tag, "_hold_rdy"}, cmd_rdy, 0);
      chk({tag, "_hold_resp"}, resp, 8'h5A);
      cmd_rdy_UART = 1'b0;
      send_resp = 1'b1;
      if (load) push_move(nxt);
      #1 chk({tag, "_ack_resp"}, resp, final_ack ? 8'hA5 : 8'h5A);
      @(posedge clk); #1 send_resp = 1'b0;
   endtask

   task automatic run_tour(input int stop_at);
      push_move(tour[0]);
      pulse_start();
      for (int i = 0; i < 24; i++) begin
         leg($sformatf("y%0d", i), i, 1'b0, i == 1, i == 0, 1'b0, 8'h00);
         if (i == stop_at) begin
            @(negedge clk);
            chk("rst_pre_rdy", cmd_rdy, 1);
            chk("rst_pre_idx", mv_indx, i);
            cmd_UART = 16'h2468;
            rst_n = 1'b0;
            #1;
            chk("rst_cmd", cmd, 16'h2468);
            chk("rst_rdy", cmd_rdy, 0);
            chk("rst_resp", resp, 8'hA5);
            chk("rst_idx", mv_indx, 0);
            sb.delete();
            #2 rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("no_resume_rdy", cmd_rdy, 0);
            chk("no_resume_cmd", cmd, 16'h2468);
            return;
         end
         leg($sformatf("x%0d", i), i, i == 23, 1'b0, 1'b0, i < 23, (i < 23) ? tour[i+1] : 8'h00);
      end
      @(negedge clk);
      cmd_UART = 16'h1357;
      #1;
      chk("end_cmd", cmd, 16'h1357);
      chk("end_rdy", cmd_rdy, 0);
      chk("end_resp", resp, 8'hA5);
   endtask

   initial begin
      tour[0] = 8'h20;
      tour[1] = 8'h01;
      tour[2] = 8'h08;
      tour[3] = 8'h40;
      tour[4] = 8'h28;
      for (int i = 5; i < 24; i++) begin
         int k;
         k = int'($urandom_range(0, 7));
         tour[i] = 8'(1 << k);
         if ($urandom_range(0, 2) == 0) tour[i] = tour[i] | 8'h80;
      end

      cmd_UART = 16'h1234;
      cmd_rdy_UART = 1'b1;
      #3;
      chk("reset_cmd", cmd, 16'h1234);
      chk("reset_rdy", cmd_rdy, 1);
      chk("reset_resp", resp, 8'hA5);
      chk("reset_idx", mv_indx, 0);
      #10 rst_n = 1'b1;

      @(negedge clk);
      cmd_UART = 16'h4BF1;
      cmd_rdy_UART = 1'b1;
      #1;
      chk("idle_cmd", cmd, 16'h4BF1);
      chk("idle_rdy", cmd_rdy, 1);
      cmd_rdy_UART = 1'b0;
      #1 chk("idle_rdy_low", cmd_rdy, 0);

      run_tour(-1);
      run_tour(7);
      run_tour(-1);

      // empty move: enter VERT, issue nothing, drop back to IDLE
      sb.delete();
      move = 8'h00;
      pulse_start();
      @(negedge clk);
      chk("zero_rdy", cmd_rdy, 0);
      chk("zero_resp", resp, 8'hA5);
      @(negedge clk);
      cmd_UART = 16'h4BF1;
      cmd_rdy_UART = 1'b1;
      #1;
      chk("zero_idle_cmd", cmd, 16'h4BF1);
      chk("zero_idle_rdy", cmd_rdy, 1);
      chk("zero_idle_resp", resp, 8'hA5);
      cmd_rdy_UART = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
